// File: rtl/load_store_queue_pkg.sv
// load_store_queue_pkg: shared op encodings, memory size codes and IO window for the load/store queue
package load_store_queue_pkg;
  localparam logic OP_STORE = 1'b1;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  localparam logic [1:0] SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2;
  localparam logic [1:0] IO_WINDOW = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} lsq_state_e;
  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_WINDOW;
  endfunction
  // undefined funct3 codes fall through to their low bits so the bus size always equals funct3[1:0]
  function automatic logic [1:0] mem_size_of(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? SIZE_B :
           (f3 == F3_H || f3 == F3_HU) ? SIZE_H :
           (f3 == F3_W) ? SIZE_W : f3[1:0];
  endfunction
endpackage

// File: rtl/load_store_queue_load_extend.sv
// load_extend: sign/zero-extend raw load data to 32 bits according to funct3
module load_extend
  import load_store_queue_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);
  logic       sx;
  logic [1:0] sz;
  always_comb begin
    sz = mem_size_of(funct3);
    sx = funct3 == F3_B || funct3 == F3_H;
    result = sz == SIZE_B ? {{24{sx & raw[7]}}, raw[7:0]} :
             sz == SIZE_H ? {{16{sx & raw[15]}}, raw[15:0]} : raw;
  end
endmodule

// File: rtl/load_store_queue.sv
// load_store_queue: in-order LSQ snooping CDB channels, issuing one memory access at a time
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH_BIT = 3,
  parameter int ROB_BIT   = 5,
  parameter int NUM_CDB   = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       clear_in,
  input  logic                       disp_valid,
  input  logic [3:0]                 disp_type,
  input  logic [ROB_BIT-1:0]         disp_rob_id,
  input  logic [31:0]                disp_v1,
  input  logic [31:0]                disp_v2,
  input  logic                       disp_q1_busy,
  input  logic                       disp_q2_busy,
  input  logic [ROB_BIT-1:0]         disp_q1,
  input  logic [ROB_BIT-1:0]         disp_q2,
  input  logic [31:0]                disp_imm,
  output logic                       full_out,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]      cdb_val,
  input  logic [ROB_BIT-1:0]         rob_head_id,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [1:0]                 mem_size,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata,
  output logic                       res_valid,
  output logic [ROB_BIT-1:0]         res_rob_id,
  output logic [31:0]                res_val
);
  localparam int DEPTH = 2 ** DEPTH_BIT;
  logic [DEPTH-1:0]     valid, q1_busy, q2_busy;
  logic [3:0]           typ [DEPTH];
  logic [ROB_BIT-1:0]   rob [DEPTH], q1 [DEPTH], q2 [DEPTH];
  logic [31:0]          v1 [DEPTH], v2 [DEPTH], imm [DEPTH];
  logic [32:0]          sn1 [DEPTH], sn2 [DEPTH];
  logic [DEPTH_BIT-1:0] head, tail;
  logic [DEPTH_BIT:0]   count;
  lsq_state_e           state, state_nx;
  logic [ROB_BIT-1:0]   cur_rob;
  logic [2:0]           cur_f3;
  logic [31:0]          head_addr, ext_val;
  logic [32:0]          s1, s2;
  logic                 go, issue, pop, push;
  // {hit, value}; scanning downward lets the lowest matching channel win
  function automatic logic [32:0] snoop(input logic [ROB_BIT-1:0] tag);
    logic [32:0] r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--)
      if (cdb_valid[c] && cdb_rob_id[c*ROB_BIT +: ROB_BIT] == tag) r = {1'b1, cdb_val[c*32 +: 32]};
    return r;
  endfunction
  assign full_out = count == (DEPTH_BIT+1)'(DEPTH);
  always_comb begin
    go = rdy_in && !clear_in;
    head_addr = v1[head] + imm[head];
    issue = state == IDLE && valid[head] && !q1_busy[head] && !q2_busy[head] &&
            ((typ[head][3] != OP_STORE && !is_io(head_addr)) || rob[head] == rob_head_id);
    pop = go && issue;
    push = go && disp_valid && (!full_out || pop);
    s1 = snoop(disp_q1);
    s2 = snoop(disp_q2);
    for (int i = 0; i < DEPTH; i++) begin
      sn1[i] = snoop(q1[i]);
      sn2[i] = snoop(q2[i]);
    end
    state_nx = !rdy_in ? state :
               state == IDLE ? (pop ? WAIT_MEM : IDLE) :
               mem_done ? IDLE : clear_in ? DRAIN : state;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      {valid, q1_busy, q2_busy, head, tail, count} <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        {valid, head, tail, count} <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sn1[i][32]) q1_busy[i] <= 1'b0;
          if (sn2[i][32]) q2_busy[i] <= 1'b0;
        end
        if (pop) begin
          valid[head] <= 1'b0;
          head <= head + DEPTH_BIT'(1);
        end
        if (push) begin
          valid[tail] <= 1'b1;
          q1_busy[tail] <= disp_q1_busy && !s1[32];
          q2_busy[tail] <= disp_q2_busy && !s2[32];
          tail <= tail + DEPTH_BIT'(1);
        end
        count <= count + (DEPTH_BIT+1)'(push) - (DEPTH_BIT+1)'(pop);
      end
    end
  always_ff @(posedge clk_in)
    if (go) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q1_busy[i] && sn1[i][32]) v1[i] <= sn1[i][31:0];
        if (q2_busy[i] && sn2[i][32]) v2[i] <= sn2[i][31:0];
      end
      if (push) begin
        typ[tail] <= disp_type;
        rob[tail] <= disp_rob_id;
        v1[tail]  <= disp_q1_busy && s1[32] ? s1[31:0] : disp_v1;
        v2[tail]  <= disp_q2_busy && s2[32] ? s2[31:0] : disp_v2;
        q1[tail]  <= disp_q1;
        q2[tail]  <= disp_q2;
        imm[tail] <= disp_imm;
      end
    end
  load_extend u_ext (.funct3(cur_f3), .raw(mem_rdata), .result(ext_val));
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      {mem_req, mem_we, mem_addr, mem_wdata, mem_size, res_valid, res_rob_id, res_val, cur_rob, cur_f3} <= '0;
    end else if (rdy_in) begin
      res_valid <= 1'b0;
      if (pop) begin
        mem_req   <= 1'b1;
        mem_we    <= typ[head][3] == OP_STORE;
        mem_addr  <= head_addr;
        mem_wdata <= v2[head];
        mem_size  <= mem_size_of(typ[head][2:0]);
        cur_rob   <= rob[head];
        cur_f3    <= typ[head][2:0];
      end else if (state != IDLE && mem_done) begin
        mem_req <= 1'b0;
        if (state == WAIT_MEM && !clear_in) begin
          res_valid  <= 1'b1;
          res_rob_id <= cur_rob;
          res_val    <= mem_we ? '0 : ext_val;
        end
      end
    end
endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: vector table plus directed sequences, results checked through a scoreboard
module tb_load_store_queue;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clear_in, disp_valid, disp_q1_busy, disp_q2_busy;
  logic [3:0]  disp_type;
  logic [4:0]  disp_rob_id, disp_q1, disp_q2, rob_head_id, res_rob_id;
  logic [31:0] disp_v1, disp_v2, disp_imm, mem_addr, mem_wdata, mem_rdata, res_val;
  logic        full_out, mem_req, mem_we, mem_done, res_valid;
  logic [1:0]  cdb_valid, mem_size;
  logic [9:0]  cdb_rob_id;
  logic [63:0] cdb_val;
  int checks = 0, errors = 0;

  typedef struct {logic [4:0] rob; logic [31:0] val;} exp_t;
  exp_t sb[$];
  typedef struct {
    logic [3:0] typ; logic [4:0] rob; logic [31:0] v1, v2, imm, rdata, exp_addr;
    logic exp_we; logic [1:0] exp_size; logic [31:0] exp_val;
  } vec_t;
  vec_t vec [8];

  load_store_queue dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .full_out(full_out),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .rob_head_id(rob_head_id),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_rob_id(res_rob_id), .res_val(res_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic dispatch(input logic [3:0] t, input logic [4:0] r, input logic [31:0] a, d, i,
                          input logic b1, input logic [4:0] tg);
    disp_type = t; disp_rob_id = r; disp_v1 = a; disp_v2 = d; disp_imm = i;
    disp_q1_busy = b1; disp_q1 = tg; disp_valid = 1'b1;
    @(negedge clk_in);
    disp_valid = 1'b0; disp_q1_busy = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk_in);
    chk(nm, mem_req, 1);
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rdata = d; mem_done = 1'b1;
    @(negedge clk_in);
    mem_done = 1'b0;
  endtask

  task automatic get_result(input string nm);
    exp_t e;
    for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk_in);
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL %s res_valid got 0 want 1 (timeout)", nm);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected result tag %0d val %h", nm, res_rob_id, res_val);
    end else begin
      e = sb.pop_front();
      if (res_rob_id !== e.rob || res_val !== e.val) begin
        errors++;
        $display("FAIL %s result got tag %0d val %h want tag %0d val %h", nm, res_rob_id, res_val, e.rob, e.val);
      end
    end
    @(negedge clk_in);
    chk({nm, " strobe one cycle"}, res_valid, 0);
  endtask

  initial begin
    vec[0] = '{4'b1010, 5'd3, 32'h100,      32'hDEADBEEF, 32'h4,  32'hFFFFFFFF, 32'h104,  1'b1, 2'd2, 32'h0};
    vec[1] = '{4'b0000, 5'd1, 32'h1000,     32'h0,        32'h10, 32'h000000F0, 32'h1010, 1'b0, 2'd0, 32'hFFFFFFF0};
    vec[2] = '{4'b0100, 5'd2, 32'h1000,     32'h0,        32'h10, 32'h000000F0, 32'h1010, 1'b0, 2'd0, 32'h000000F0};
    vec[3] = '{4'b0001, 5'd4, 32'h1000,     32'h0,        32'h10, 32'h00008001, 32'h1010, 1'b0, 2'd1, 32'hFFFF8001};
    vec[4] = '{4'b0101, 5'd5, 32'h1000,     32'h0,        32'h10, 32'h00008001, 32'h1010, 1'b0, 2'd1, 32'h00008001};
    vec[5] = '{4'b0010, 5'd6, 32'h1000,     32'h0,        32'h10, 32'h12345678, 32'h1010, 1'b0, 2'd2, 32'h12345678};
    vec[6] = '{4'b1000, 5'd7, 32'h2000,     32'hAABBCCDD, 32'h1,  32'h0000005A, 32'h2001, 1'b1, 2'd0, 32'h0};
    vec[7] = '{4'b0010, 5'd9, 32'hFFFFFFF0, 32'h0,        32'h20, 32'h0BADF00D, 32'h10,   1'b0, 2'd2, 32'h0BADF00D};
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0; disp_type = '0;
    disp_rob_id = '0; disp_v1 = '0; disp_v2 = '0; disp_imm = '0; disp_q1_busy = 1'b0;
    disp_q2_busy = 1'b0; disp_q1 = '0; disp_q2 = '0; cdb_valid = '0; cdb_rob_id = '0;
    cdb_val = '0; rob_head_id = '0; mem_done = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk_in);
    chk("reset full_out", full_out, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset mem_addr", mem_addr, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int k = 0; k < 8; k++) begin
      rob_head_id = vec[k].rob;
      dispatch(vec[k].typ, vec[k].rob, vec[k].v1, vec[k].v2, vec[k].imm, 1'b0, 5'd0);
      sb.push_back('{vec[k].rob, vec[k].exp_val});
      wait_req($sformatf("v%0d req", k));
      chk($sformatf("v%0d addr", k), mem_addr, vec[k].exp_addr);
      chk($sformatf("v%0d we", k), mem_we, vec[k].exp_we);
      chk($sformatf("v%0d size", k), mem_size, vec[k].exp_size);
      if (vec[k].exp_we) chk($sformatf("v%0d wdata", k), mem_wdata, vec[k].v2);
      respond(vec[k].rdata);
      chk($sformatf("v%0d req drop", k), mem_req, 0);
      get_result($sformatf("v%0d", k));
    end

    // operand broadcast on channel 1 in the dispatch cycle; load is speculative (tag differs)
    rob_head_id = 5'd9;
    cdb_valid = 2'b10; cdb_rob_id = {5'd7, 5'd7}; cdb_val = {32'h200, 32'h300};
    dispatch(4'b0010, 5'd8, 32'hBAD, 32'h0, 32'h8, 1'b1, 5'd7);
    cdb_valid = 2'b00;
    @(negedge clk_in);
    chk("bypass req", mem_req, 1);
    chk("bypass addr", mem_addr, 32'h208);
    sb.push_back('{5'd8, 32'hCAFE0000});
    respond(32'hCAFE0000);
    get_result("bypass");

    // late wake-up, both channels match: channel 0 value must be taken
    rob_head_id = 5'd12;
    dispatch(4'b0010, 5'd12, 32'hBAD, 32'h0, 32'h10, 1'b1, 5'd5);
    repeat (3) @(negedge clk_in);
    chk("wakeup waits", mem_req, 0);
    cdb_valid = 2'b11; cdb_rob_id = {5'd5, 5'd5}; cdb_val = {32'h500, 32'h400};
    @(negedge clk_in);
    cdb_valid = 2'b00;
    wait_req("wakeup req");
    chk("wakeup addr", mem_addr, 32'h410);
    sb.push_back('{5'd12, 32'h1});
    respond(32'h1);
    get_result("wakeup");

    // IO load waits for commit; non-IO load issues speculatively
    rob_head_id = 5'd2;
    dispatch(4'b0010, 5'd4, 32'h30000, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (4) @(negedge clk_in);
    chk("io waits", mem_req, 0);
    rob_head_id = 5'd4;
    wait_req("io req");
    chk("io addr", mem_addr, 32'h30000);
    sb.push_back('{5'd4, 32'h42});
    respond(32'h42);
    get_result("io");
    rob_head_id = 5'd2;
    dispatch(4'b0010, 5'd6, 32'h1000, 32'h0, 32'h0, 1'b0, 5'd0);
    wait_req("spec req");
    chk("spec addr", mem_addr, 32'h1000);
    sb.push_back('{5'd6, 32'h43});
    respond(32'h43);
    get_result("spec");

    // fill with blocked IO loads, then enqueue and pop in the same cycle
    rob_head_id = 5'd0;
    for (int k = 0; k < 8; k++) begin
      dispatch(4'b0010, 5'(10 + k), 32'h30000, 32'h0, 32'h0, 1'b0, 5'd0);
      if (k == 6) chk("seven not full", full_out, 0);
    end
    chk("eight full", full_out, 1);
    rob_head_id = 5'd10;
    dispatch(4'b0010, 5'd18, 32'h30000, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("push+pop stays full", full_out, 1);
    chk("push+pop req", mem_req, 1);
    sb.push_back('{5'd10, 32'h11223344});
    respond(32'h11223344);
    get_result("full pop");
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    chk("clear empties", full_out, 0);
    rob_head_id = 5'd11;
    repeat (3) @(negedge clk_in);
    chk("cleared no issue", mem_req, 0);

    // flush while a store is outstanding
    rob_head_id = 5'd20;
    dispatch(4'b1010, 5'd20, 32'h2000, 32'h55, 32'h0, 1'b0, 5'd0);
    wait_req("drain req");
    dispatch(4'b0010, 5'd21, 32'h30000, 32'h0, 32'h0, 1'b0, 5'd0);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    chk("drain full_out", full_out, 0);
    repeat (2) @(negedge clk_in);
    chk("drain req held", mem_req, 1);
    respond(32'h0);
    chk("drain no result", res_valid, 0);
    chk("drain req drop", mem_req, 0);
    rob_head_id = 5'd21;
    repeat (3) @(negedge clk_in);
    chk("drain queue flushed", mem_req, 0);

    // rdy_in low freezes the outstanding access
    rob_head_id = 5'd22;
    dispatch(4'b0010, 5'd22, 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0);
    wait_req("freeze req");
    rdy_in = 1'b0;
    respond(32'h99);
    chk("freeze req held", mem_req, 1);
    chk("freeze no result", res_valid, 0);
    rdy_in = 1'b1;
    sb.push_back('{5'd22, 32'h77});
    respond(32'h77);
    get_result("freeze");

    // asynchronous reset in the middle of a store
    rob_head_id = 5'd23;
    dispatch(4'b1010, 5'd23, 32'h4000, 32'h66, 32'h8, 1'b0, 5'd0);
    wait_req("areset req");
    #2 rst_n_in = 1'b0;
    #1;
    chk("areset mem_req", mem_req, 0);
    chk("areset mem_we", mem_we, 0);
    chk("areset mem_addr", mem_addr, 0);
    chk("areset mem_wdata", mem_wdata, 0);
    chk("areset mem_size", mem_size, 0);
    chk("areset res_valid", res_valid, 0);
    chk("areset full_out", full_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
